rs_flag_sequencer: RTL
======================

Name: rs_flag_sequencer

Overview:
- Shares a bank of NFF RS flip-flops (flag register) between NREQ requesters.
- Round-robin arbitration; each granted command drives a single S or R pulse to one flip-flop, then reads back Q to confirm.
- By construction, S and R are never both asserted on any flip-flop, so the forbidden S=R=1 input never occurs.
- Sits between software/FSM requesters and the RS flip-flop bank; S_out/R_out drive the bank, Q_in returns its outputs.

Parameters:
- NREQ, 2, number of requesters (2..8)
- NFF, 4, number of RS flip-flops in the bank
- IDXW, 2, width of the flip-flop index field (ceil(log2(NFF)), min 1)
- PULSE_LEN, 2, cycles S/R is held high (>=1; 2 covers one full flip-flop clock period)

Ports:
- CLK_in  input  1  single clock, rising edge
- RST_in  input  1  synchronous, active-high reset
- REQ_in  input  NREQ  per-requester request level
- OP_in  input  NREQ  per-requester op: 1=set (S), 0=reset (R)
- IDX_in  input  NREQ*IDXW  per-requester target index; requester k uses bits [k*IDXW +: IDXW]
- Q_in  input  NFF  Q outputs of the flip-flop bank
- GNT_out  output  NREQ  one-hot grant, 1-cycle pulse
- DONE_out  output  NREQ  one-hot completion, 1-cycle pulse
- ERR_out  output  1  1-cycle pulse, coincident with DONE_out, on failure
- S_out  output  NFF  set lines to the bank
- R_out  output  NFF  reset lines to the bank

Behaviour:
- All outputs are registered.
- Reset (RST_in=1 at edge):
  - state=IDLE, rr pointer=0.
  - GNT_out, DONE_out, ERR_out, S_out, R_out all 0.
  - Takes effect at that edge even mid-operation: the pulse is truncated and no DONE is issued.
- FSM states: IDLE -> PULSE -> CHECK -> RESP -> IDLE.
- IDLE:
  - REQ_in is sampled only in IDLE.
  - If any bit is set, the winner is the first set bit at or after the rr pointer, searched circularly.
  - Latch winner, OP_in[winner] and IDX[winner].
  - Next state PULSE; GNT_out[winner]=1 for the first PULSE cycle only.
- PULSE (PULSE_LEN cycles, counter):
  - op=1: S_out[idx]=1.
  - op=0: R_out[idx]=1.
  - All other S/R bits stay 0.
- CHECK (1 cycle):
  - S_out=R_out=0.
  - Q_in[idx] is sampled at the end of this cycle.
- RESP (1 cycle):
  - DONE_out[winner]=1.
  - ERR_out=1 if the sampled Q != op.
  - rr pointer <- (winner+1) mod NREQ.
- Latency: GNT in cycle 1 after the request is sampled; DONE in cycle PULSE_LEN+2; back-to-back throughput is one op per PULSE_LEN+3 cycles.
- Out-of-range idx (idx >= NFF): no pulse. Go PULSE-skipped straight to RESP the next cycle with DONE=1, ERR=1.
- Requester protocol:
  - Hold REQ/OP/IDX stable until GNT.
  - After GNT, the winner's inputs are ignored until RESP.
  - REQ still high when the FSM returns to IDLE is treated as a new request.
- Invariants checked every cycle:
  - (S_out & R_out)==0.
  - popcount(S_out|R_out) <= 1.
  - popcount(GNT_out) <= 1.
  - popcount(DONE_out) <= 1.
- Fairness: with all requesters continuously active, grants rotate 0,1,..,NREQ-1,0; no requester waits more than NREQ-1 ops.

Decomposition:
- Shared package/header rs_seq_defs:
  - FSM state encodings (IDLE=2'd0, PULSE=2'd1, CHECK=2'd2, RESP=2'd3).
  - OP_SET=1, OP_RST=0.
- One sub-module: rr_arbiter. Combinational round-robin pick from a request vector and pointer; outputs one-hot grant plus a valid flag.
- The sequencer holds the FSM, pulse counter, latches and pointer.

Test Plan:
- Set op: after reset, REQ_in=01, OP=1, IDX0=2, bench RS bank connected -> GNT_out=01 next cycle; S_out=0100 for 2 cycles, R_out=0; DONE_out=01 at cycle 4; ERR=0; Q_in[2]=1.
- Clear op: then REQ_in=01, OP=0, IDX0=2 -> R_out=0100 for 2 cycles, S_out=0; DONE=01, ERR=0; Q[2]=0.
- Contention: REQ_in=11 held continuously, IDX0=0 set, IDX1=1 set -> grant order 01,10,01,10; each DONE 5 cycles apart; no S/R overlap.
- Failure: Q_in stuck at 0000, REQ0 set IDX=3 -> S_out=1000 pulse; DONE=01 with ERR=1. Separately, NFF=3 with IDX=3 -> no S/R activity, DONE+ERR 2 cycles after the request is sampled.
- Reset mid-pulse: RST_in=1 during the first PULSE cycle -> next cycle S_out=R_out=0, no DONE, rr pointer=0; a subsequent REQ_in=10 is granted normally.
- Random soak: 10k cycles of random REQ/OP/IDX with an RS bank model. Assertions hold (S&R==0, one-hot grant/done). Every GNT is matched by exactly one DONE, and the model Q agrees with ERR.

Source files
------------

// File: rtl/rs_flag_sequencer_pkg.sv
// Shared definitions for the RS flag sequencer: FSM state encodings, op codes
// and a width helper used to size pointers and counters.
package rs_flag_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_RST = 1'b0;

  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rs_flag_sequencer_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after the
// pointer, searched circularly; one-hot grant, binary index and valid flag.
module rs_flag_sequencer_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned k;
    k       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr_i) + i) % NREQ;
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/rs_flag_sequencer.sv
// Round-robin sequencer sharing a bank of RS flip-flops between requesters:
// each granted command pulses one S or R line, then reads Q back to confirm.
module rs_flag_sequencer #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned NFF       = 4,
  parameter int unsigned IDXW      = 2,
  parameter int unsigned PULSE_LEN = 2
) (
  input  logic                   CLK_in,
  input  logic                   RST_in,
  input  logic [NREQ-1:0]        REQ_in,
  input  logic [NREQ-1:0]        OP_in,
  input  logic [NREQ*IDXW-1:0]   IDX_in,
  input  logic [NFF-1:0]         Q_in,
  output logic [NREQ-1:0]        GNT_out,
  output logic [NREQ-1:0]        DONE_out,
  output logic                   ERR_out,
  output logic [NFF-1:0]         S_out,
  output logic [NFF-1:0]         R_out
);
  import rs_flag_sequencer_pkg::*;

  localparam int unsigned PW = min1_clog2(NREQ);
  localparam int unsigned CW = min1_clog2(PULSE_LEN + 1);

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   winidx_q;
  logic [NREQ-1:0] win_q;
  logic            op_q;
  logic            oor_q;
  logic [NFF-1:0]  mask_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_valid;
  logic            op_d;
  logic            oor_d;
  logic [IDXW-1:0] idx_d;
  logic [NFF-1:0]  mask_d;
  logic [PW-1:0]   ptr_d;

  rs_flag_sequencer_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i   (REQ_in),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Mask stays all-zero for an out-of-range index, so no line can pulse.
  always_comb begin
    op_d  = 1'b0;
    idx_d = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        op_d  = OP_in[k];
        idx_d = IDX_in[k*IDXW +: IDXW];
      end
    end
    oor_d  = (32'(idx_d) >= NFF);
    mask_d = '0;
    for (int unsigned f = 0; f < NFF; f++) begin
      mask_d[f] = (32'(idx_d) == f);
    end
    ptr_d = (winidx_q == PW'(NREQ - 1)) ? '0 : winidx_q + PW'(1);
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      winidx_q <= '0;
      win_q    <= '0;
      op_q     <= 1'b0;
      oor_q    <= 1'b0;
      mask_q   <= '0;
      cnt_q    <= '0;
      GNT_out  <= '0;
      DONE_out <= '0;
      ERR_out  <= 1'b0;
      S_out    <= '0;
      R_out    <= '0;
    end else begin
      GNT_out  <= '0;
      DONE_out <= '0;
      ERR_out  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            win_q    <= arb_gnt;
            winidx_q <= arb_idx;
            op_q     <= op_d;
            oor_q    <= oor_d;
            mask_q   <= mask_d;
            cnt_q    <= CW'(1);
            GNT_out  <= arb_gnt;
            S_out    <= (op_d == OP_SET) ? mask_d : '0;
            R_out    <= (op_d == OP_RST) ? mask_d : '0;
            state_q  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (oor_q) begin
            DONE_out <= win_q;
            ERR_out  <= 1'b1;
            state_q  <= ST_RESP;
          end else if (cnt_q == CW'(PULSE_LEN)) begin
            S_out   <= '0;
            R_out   <= '0;
            state_q <= ST_CHECK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_CHECK: begin
          DONE_out <= win_q;
          ERR_out  <= ((|(Q_in & mask_q)) != op_q);
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
